// File: rtl/icache_ctrl_pkg.sv
// Shared FSM state encoding and address-field positions for icache_ctrl.
// ICACHE_INV_EN adds the INV (whole-cache invalidate) state.
package icache_ctrl_pkg;

  localparam int ADDR_W  = 32;
  localparam int OFS_BIT = 2;   // byte offset within a 32-bit word

`ifdef ICACHE_INV_EN
  typedef enum logic [2:0] {
    S_IDLE, S_LOOKUP, S_MISS, S_REFILL, S_RESP, S_INV
  } state_e;
`else
  typedef enum logic [2:0] {
    S_IDLE, S_LOOKUP, S_MISS, S_REFILL, S_RESP
  } state_e;
`endif

  // Address layout: {tag, set index, word offset, byte offset}
  function automatic int word_lsb();
    return OFS_BIT;
  endfunction

  function automatic int idx_lsb(input int word_bit);
    return OFS_BIT + word_bit;
  endfunction

  function automatic int tag_lsb(input int word_bit, input int blkidx_bit);
    return OFS_BIT + word_bit + blkidx_bit;
  endfunction

endpackage

// File: rtl/icache_ctrl.sv
// Direct-mapped instruction cache controller: valid bits internal, tag/data arrays external.
// Define ICACHE_INV_EN to add inv_req/inv_busy and a sequential whole-cache invalidate.
module icache_ctrl
  import icache_ctrl_pkg::*;
#(
  parameter int BLKIDX_BIT = 4,
  parameter int WORD_BIT   = 2,
  parameter int TAG_BIT    = 32 - BLKIDX_BIT - WORD_BIT - 2
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  cpu_req,
  input  logic [31:0]           cpu_addr,
  output logic                  cpu_ack,
  output logic [31:0]           cpu_rdata,
  output logic                  meta_wen,
  output logic [BLKIDX_BIT-1:0] meta_blkidx,
  output logic [TAG_BIT-1:0]    meta_wdata,
  input  logic [TAG_BIT-1:0]    meta_rdata,
  output logic                  data_wen,
  output logic [BLKIDX_BIT-1:0] data_blkidx,
  output logic [WORD_BIT-1:0]   data_word,
  output logic [31:0]           data_wdata,
  input  logic [31:0]           data_rdata,
`ifdef ICACHE_INV_EN
  input  logic                  inv_req,
  output logic                  inv_busy,
`endif
  output logic                  mem_req,
  output logic [31:0]           mem_addr,
  input  logic                  mem_ack,
  input  logic                  mem_rvalid,
  input  logic [31:0]           mem_rdata
);

  localparam int SETS     = 1 << BLKIDX_BIT;
  localparam int WORD_LSB = word_lsb();
  localparam int IDX_LSB  = idx_lsb(WORD_BIT);
  localparam int TAG_LSB  = tag_lsb(WORD_BIT, BLKIDX_BIT);

  state_e                state_q, state_d;
  logic [31:0]           addr_q, addr_d;
  logic [SETS-1:0]       valid_q, valid_d;
  logic [WORD_BIT-1:0]   beat_q, beat_d;
  logic [31:0]           resp_q, resp_d;
`ifdef ICACHE_INV_EN
  logic [BLKIDX_BIT-1:0] inv_cnt_q, inv_cnt_d;
`endif

  logic [TAG_BIT-1:0]    tag_a;
  logic [BLKIDX_BIT-1:0] idx_a;
  logic [WORD_BIT-1:0]   word_a;
  logic                  hit;

  assign tag_a  = addr_q[ADDR_W-1:TAG_LSB];
  assign idx_a  = addr_q[TAG_LSB-1:IDX_LSB];
  assign word_a = addr_q[IDX_LSB-1:WORD_LSB];
  assign hit    = valid_q[idx_a] && (meta_rdata == tag_a);

  assign meta_blkidx = idx_a;
  assign meta_wdata  = tag_a;
  assign data_blkidx = idx_a;
  assign data_wdata  = mem_rdata;
  // The array is addressed by the fill counter while refilling, else by the requested word.
  assign data_word   = (state_q == S_REFILL) ? beat_q : word_a;
`ifdef ICACHE_INV_EN
  assign inv_busy    = (state_q == S_INV);
`endif

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    valid_d   = valid_q;
    beat_d    = beat_q;
    resp_d    = resp_q;
`ifdef ICACHE_INV_EN
    inv_cnt_d = inv_cnt_q;
`endif
    cpu_ack   = 1'b0;
    cpu_rdata = '0;
    mem_req   = 1'b0;
    mem_addr  = '0;
    meta_wen  = 1'b0;
    data_wen  = 1'b0;
    case (state_q)
      S_IDLE: begin
`ifdef ICACHE_INV_EN
        if (inv_req) begin
          state_d   = S_INV;
          inv_cnt_d = '0;
        end else
`endif
        if (cpu_req) begin
          addr_d  = cpu_addr;
          state_d = S_LOOKUP;
        end
      end
      S_LOOKUP: begin
        if (hit) begin
          cpu_ack   = 1'b1;
          cpu_rdata = data_rdata;
          state_d   = S_IDLE;
        end else begin
          state_d = S_MISS;
        end
      end
      S_MISS: begin
        mem_req  = 1'b1;
        mem_addr = {tag_a, idx_a, {(WORD_BIT + OFS_BIT){1'b0}}};
        if (mem_ack) begin
          beat_d  = '0;
          state_d = S_REFILL;
        end
      end
      S_REFILL: begin
        data_wen = mem_rvalid;
        if (mem_rvalid) begin
          beat_d = beat_q + WORD_BIT'(1);
          if (beat_q == word_a) resp_d = mem_rdata;
          // Tag and valid are committed only with the last beat, so an aborted fill leaves the set invalid.
          if (&beat_q) begin
            meta_wen       = 1'b1;
            valid_d[idx_a] = 1'b1;
            state_d        = S_RESP;
          end
        end
      end
      S_RESP: begin
        cpu_ack   = 1'b1;
        cpu_rdata = resp_q;
        state_d   = S_IDLE;
      end
`ifdef ICACHE_INV_EN
      S_INV: begin
        valid_d[inv_cnt_q] = 1'b0;
        inv_cnt_d          = inv_cnt_q + BLKIDX_BIT'(1);
        if (&inv_cnt_q) state_d = S_IDLE;
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      valid_q   <= '0;
      beat_q    <= '0;
      resp_q    <= '0;
`ifdef ICACHE_INV_EN
      inv_cnt_q <= '0;
`endif
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      valid_q   <= valid_d;
      beat_q    <= beat_d;
      resp_q    <= resp_d;
`ifdef ICACHE_INV_EN
      inv_cnt_q <= inv_cnt_d;
`endif
    end
  end

endmodule

// File: doc/icache_ctrl.md
ICACHE_CTRL -- requirements
Module: icache_ctrl

Interface
REQ-001 SHALL have parameter BLKIDX_BIT, default 4, meaning number of set-index bits (sets = 2^BLKIDX_BIT).
REQ-002 SHALL have parameter WORD_BIT, default 2, meaning word-offset bits (words per line = 2^WORD_BIT).
REQ-003 SHALL have parameter TAG_BIT, default 32-BLKIDX_BIT-WORD_BIT-2, meaning tag width.
REQ-004 SHALL have clk  input  1  rising-edge clock.
REQ-005 SHALL have resetn  input  1  asynchronous, active-low reset.
REQ-006 SHALL have cpu_req  input  1  fetch request, held until cpu_ack.
REQ-007 SHALL have cpu_addr  input  32  fetch byte address, word aligned.
REQ-008 SHALL have cpu_ack  output  1  one-cycle pulse, cpu_rdata valid.
REQ-009 SHALL have cpu_rdata  output  32  fetched word.
REQ-010 SHALL have meta_wen, meta_blkidx[BLKIDX_BIT], meta_wdata[TAG_BIT] outputs and meta_rdata[TAG_BIT] input (combinational read) driving the tag array.
REQ-011 SHALL have data_wen, data_blkidx[BLKIDX_BIT], data_word[WORD_BIT], data_wdata[32] outputs and data_rdata[32] input (combinational read) driving the data array.
REQ-012 SHALL have mem_req  output  1, mem_addr  output  32 (line aligned), mem_ack  input  1, mem_rvalid  input  1, mem_rdata  input  32.

Function
REQ-013 FSM states SHALL be IDLE, LOOKUP, MISS, REFILL, RESP (plus INV when configured).
REQ-014 IDLE with cpu_req SHALL latch cpu_addr and go to LOOKUP next cycle.
REQ-015 LOOKUP SHALL drive meta/data blkidx and word from the latched address; hit = valid[idx] and meta_rdata==tag.
REQ-016 On hit, cpu_ack SHALL pulse in LOOKUP with cpu_rdata=data_rdata; next state IDLE (hit latency 2 cycles from cpu_req sampled in IDLE).
REQ-017 On miss, next state MISS; mem_req SHALL be 1 with mem_addr={tag,idx,0} until the cycle mem_ack=1, then REFILL.
REQ-018 REFILL SHALL write each mem_rvalid beat to data_word=beat counter (wraps 0..2^WORD_BIT-1), data_wen=mem_rvalid only.
REQ-019 The beat whose counter equals the requested word SHALL be captured into a response register.
REQ-020 On final beat, meta_wen=1 with meta_wdata=tag and valid[idx] set at that edge; next state RESP.
REQ-021 RESP SHALL pulse cpu_ack with the captured word, then IDLE.
REQ-022 mem_rvalid outside REFILL SHALL be ignored; mem_ack outside MISS SHALL be ignored.
REQ-023 meta_wen and data_wen SHALL never be 1 outside REFILL.

Reset
REQ-024 resetn=0 SHALL asynchronously force IDLE, clear all valid bits, beat counter, response register; outputs cpu_ack, mem_req, meta_wen, data_wen, cpu_rdata, mem_addr = 0.
REQ-025 Reset mid-refill SHALL abandon the line; that set stays invalid.

Configuration
REQ-026 With ICACHE_INV_EN defined, ports inv_req (input 1) and inv_busy (output 1) SHALL exist; inv_req sampled in IDLE enters INV, clearing one valid bit per cycle from set 0 to set 2^BLKIDX_BIT-1, inv_busy=1 throughout, then IDLE.
REQ-027 Simultaneous inv_req and cpu_req in IDLE SHALL serve INV first; inv_req in other states SHALL wait for IDLE.
REQ-028 Without ICACHE_INV_EN, no INV state and no inv ports SHALL exist; valid bits clear only on reset.

Structure
REQ-029 A shared package SHALL hold the FSM state enum and address-field slicing constants (offset/index/tag positions).
REQ-030 The valid-bit vector SHALL be internal; tag and data storage SHALL remain external; no sub-module required.

Verification
REQ-031 Reset, cpu_req addr 0x0000_0040 -> miss, mem_req with mem_addr 0x40, 4 beats 0xA0..0xA3, cpu_ack with 0xA0 in RESP.
REQ-032 Repeat addr 0x0000_0048 -> hit, cpu_ack in LOOKUP 2 cycles after request, data 0xA2, no mem_req.
REQ-033 Addr 0x0000_0140 (same index, new tag) -> miss, refill, tag replaced; then 0x40 misses again.
REQ-034 mem_ack delayed 5 cycles and mem_rvalid gaps of 3 cycles -> mem_req held, data_wen only on valid beats, correct word returned.
REQ-035 resetn low during REFILL beat 2 -> immediate IDLE, all outputs 0; next fetch of that line misses.
REQ-036 ICACHE_INV_EN: fill line 0x40, inv_req with cpu_req same cycle -> inv_busy 16 cycles, then 0x40 misses.
